// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID/EX control pipeline: opcodes, ALU selects,
// the packed control bundle and the MULT interlock FSM states.
package ctrl_pkg;

  localparam int unsigned ALU_SEL_W = 4;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_MOV   = 4'd4;
  localparam logic [3:0] OP_LOADI = 4'd5;
  localparam logic [3:0] OP_J     = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_ROR   = 4'd8;
  localparam logic [3:0] OP_SLL   = 4'd9;
  localparam logic [3:0] OP_SRL   = 4'd10;
  localparam logic [3:0] OP_SRA   = 4'd11;
  localparam logic [3:0] OP_BNE   = 4'd12;
  localparam logic [3:0] OP_MULT  = 4'd13;

  localparam logic [ALU_SEL_W-1:0] ALU_FWD = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_ROR = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL = 4'd8;

  typedef struct packed {
    logic                 wrten;
    logic                 cmplmnt_sel;
    logic                 immd_sel;
    logic [ALU_SEL_W-1:0] alu_op;
    logic                 jump;
    logic                 branch;
    logic                 bne;
  } ctrl_t;

  typedef enum logic {
    RUN,
    MULT_WAIT
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal flag.
// Opcodes above OP_MULT are illegal and decode to all-zero controls.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  // Table lookup; every unlisted field stays 0.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    if (opcode > OPCODE_W'(OP_MULT)) begin
      illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_ADD:   begin ctrl.wrten = 1'b1; ctrl.cmplmnt_sel = 1'b1; ctrl.alu_op = ALU_ADD; end
        OP_SUB:   begin ctrl.wrten = 1'b1; ctrl.alu_op = ALU_ADD; end
        OP_AND:   begin ctrl.wrten = 1'b1; ctrl.cmplmnt_sel = 1'b1; ctrl.alu_op = ALU_AND; end
        OP_OR:    begin ctrl.wrten = 1'b1; ctrl.cmplmnt_sel = 1'b1; ctrl.alu_op = ALU_OR; end
        OP_MOV:   begin ctrl.wrten = 1'b1; ctrl.cmplmnt_sel = 1'b1; ctrl.alu_op = ALU_FWD; end
        OP_LOADI: begin ctrl.wrten = 1'b1; ctrl.immd_sel = 1'b1; ctrl.alu_op = ALU_FWD; end
        OP_J:     begin ctrl.jump = 1'b1; end
        OP_BEQ:   begin ctrl.alu_op = ALU_ADD; ctrl.branch = 1'b1; end
        OP_ROR:   begin ctrl.wrten = 1'b1; ctrl.immd_sel = 1'b1; ctrl.alu_op = ALU_ROR; end
        OP_SLL:   begin ctrl.wrten = 1'b1; ctrl.immd_sel = 1'b1; ctrl.alu_op = ALU_SLL; end
        OP_SRL:   begin ctrl.wrten = 1'b1; ctrl.immd_sel = 1'b1; ctrl.alu_op = ALU_SRL; end
        OP_SRA:   begin ctrl.wrten = 1'b1; ctrl.immd_sel = 1'b1; ctrl.alu_op = ALU_SRA; end
        OP_BNE:   begin ctrl.alu_op = ALU_ADD; ctrl.bne = 1'b1; end
        OP_MULT:  begin ctrl.wrten = 1'b1; ctrl.cmplmnt_sel = 1'b1; ctrl.alu_op = ALU_MUL; end
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// ID/EX control pipeline register with stall, flush and a multi-cycle MULT
// interlock toward fetch. Optional illegal-opcode trap outputs are enabled by
// defining CTRL_ILLEGAL_TRAP_EN.
module pipelined_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 8,
  parameter int unsigned ALU_OP_W     = 4,
  parameter int unsigned MULT_LATENCY = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  output logic                id_ready,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic                ex_wrten,
  output logic                ex_cmplmnt_sel,
  output logic                ex_immd_sel,
  output logic                ex_jump,
  output logic                ex_branch,
  output logic                ex_bne,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                mult_busy
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                ex_illegal,
  output logic                illegal_seen
`endif
);

  localparam int unsigned    CNT_W      = $clog2(MULT_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);
  localparam logic           MULT_MULTI = (MULT_LATENCY > 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctrl_t            dec_ctrl, ld_ctrl, ex_ctrl;
  logic             dec_illegal;
  logic             xfer, accept;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode  (id_opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Illegal opcodes never carry controls into EX, whatever the decoder emits.
  assign ld_ctrl = dec_illegal ? '0 : dec_ctrl;
  assign xfer    = id_valid && id_ready;
  // A transfer coinciding with flush is dropped; fetch re-presents it.
  assign accept  = xfer && !flush;

  // FSM state and MULT occupancy counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: enter MULT_WAIT on an accepted multi-cycle MULT, leave when the counter hits 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!ex_stall) begin
      case (state)
        RUN: begin
          if (accept && MULT_MULTI && (id_opcode == OPCODE_W'(OP_MULT))) begin
            state_nxt = MULT_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
        MULT_WAIT: begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Handshake and interlock outputs.
  always_comb begin
    id_ready  = !RESET && !ex_stall && (state == RUN);
    mult_busy = (state == MULT_WAIT);
  end

  // EX control register: stall holds, flush and idle cycles insert a bubble.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!ex_stall) begin
      if (accept) begin
        ex_valid <= 1'b1;
        ex_ctrl  <= ld_ctrl;
      end else begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Illegal-transfer flag tracks ex_valid; illegal_seen is sticky until reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_illegal   <= 1'b0;
      illegal_seen <= 1'b0;
    end else if (!ex_stall) begin
      ex_illegal <= accept && dec_illegal;
      if (accept && dec_illegal) illegal_seen <= 1'b1;
    end
  end
`endif

  assign ex_wrten       = ex_ctrl.wrten;
  assign ex_cmplmnt_sel = ex_ctrl.cmplmnt_sel;
  assign ex_immd_sel    = ex_ctrl.immd_sel;
  assign ex_jump        = ex_ctrl.jump;
  assign ex_branch      = ex_ctrl.branch;
  assign ex_bne         = ex_ctrl.bne;
  assign ex_alu_op      = ALU_OP_W'(ex_ctrl.alu_op);

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Directed bench for pipelined_ctrl_unit (MULT_LATENCY=4).
module tb_pipelined_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RESET, id_valid, ex_stall, flush;
  logic [7:0] id_opcode;
  logic       id_ready, ex_valid, ex_wrten, ex_cmplmnt_sel, ex_immd_sel;
  logic       ex_jump, ex_branch, ex_bne, mult_busy;
  logic [3:0] ex_alu_op;
  logic [9:0] ex_vec;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       ex_illegal, illegal_seen;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipelined_ctrl_unit #(.OPCODE_W(8), .ALU_OP_W(4), .MULT_LATENCY(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_ready       (id_ready),
    .ex_stall       (ex_stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_wrten       (ex_wrten),
    .ex_cmplmnt_sel (ex_cmplmnt_sel),
    .ex_immd_sel    (ex_immd_sel),
    .ex_jump        (ex_jump),
    .ex_branch      (ex_branch),
    .ex_bne         (ex_bne),
    .ex_alu_op      (ex_alu_op),
    .mult_busy      (mult_busy)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .ex_illegal     (ex_illegal),
    .illegal_seen   (illegal_seen)
`endif
  );

  always #5 CLK = ~CLK;

  assign ex_vec = {ex_wrten, ex_cmplmnt_sel, ex_immd_sel, ex_alu_op, ex_jump, ex_branch, ex_bne};

  // Expected controls as {wrten, cmplmnt, immd, alu_op[3:0], jump, branch, bne}.
  function automatic logic [9:0] exp_ctrl(input int unsigned op);
    case (op)
      0:       return 10'b110_0001_000;
      1:       return 10'b100_0001_000;
      2:       return 10'b110_0010_000;
      3:       return 10'b110_0011_000;
      4:       return 10'b110_0000_000;
      5:       return 10'b101_0000_000;
      6:       return 10'b000_0000_100;
      7:       return 10'b000_0001_010;
      8:       return 10'b101_0100_000;
      9:       return 10'b101_0101_000;
      10:      return 10'b101_0110_000;
      11:      return 10'b101_0111_000;
      12:      return 10'b000_0001_001;
      13:      return 10'b110_1000_000;
      default: return 10'b000_0000_000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int unsigned sweep [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 255};

  initial begin
    RESET = 1'b1; id_valid = 1'b1; id_opcode = 8'd0; ex_stall = 1'b0; flush = 1'b0;

    // Reset held two cycles with a valid add on the input.
    repeat (2) begin
      tick();
      check("rst_valid", ex_valid, 0);
      check("rst_ctrl", ex_vec, 0);
      check("rst_ready", id_ready, 0);
      check("rst_busy", mult_busy, 0);
    end
    RESET = 1'b0;
    #1 check("ready_after_rst", id_ready, 1);

    // Back-to-back sweep (MULT excluded here, it stalls fetch).
    for (int i = 0; i < 16; i++) begin
      if (sweep[i] != 13) begin
        id_opcode = 8'(sweep[i]);
        tick();
        check("sweep_valid", ex_valid, 1);
        check("sweep_ctrl", ex_vec, exp_ctrl(sweep[i]));
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("sweep_illegal", ex_illegal, (sweep[i] > 13) ? 1 : 0);
`endif
      end
    end

    // MULT with latency 4, add held behind it.
    id_opcode = 8'd13;
    tick();
    check("mult_valid", ex_valid, 1);
    check("mult_ctrl", ex_vec, exp_ctrl(13));
    check("mult_busy0", mult_busy, 1);
    id_opcode = 8'd0;
    #1 check("mult_ready0", id_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("mult_wait_busy", mult_busy, (i < 3) ? 1 : 0);
      check("mult_wait_ready", id_ready, (i == 3) ? 1 : 0);
      check("mult_wait_valid", ex_valid, 0);
    end
    tick();
    check("after_mult_valid", ex_valid, 1);
    check("after_mult_ctrl", ex_vec, exp_ctrl(0));

    // Stall three cycles inside MULT_WAIT: counter freezes.
    id_opcode = 8'd13;
    tick();
    check("smult_ctrl", ex_vec, exp_ctrl(13));
    id_opcode = 8'd0;
    tick();
    check("smult_busy1", mult_busy, 1);
    ex_stall = 1'b1;
    repeat (3) begin
      tick();
      check("smult_stall_busy", mult_busy, 1);
      check("smult_stall_valid", ex_valid, 0);
      check("smult_stall_ctrl", ex_vec, 0);
      check("smult_stall_ready", id_ready, 0);
    end
    ex_stall = 1'b0;
    tick();
    check("smult_busy_last", mult_busy, 1);
    check("smult_ready_last", id_ready, 0);
    tick();
    check("smult_done_busy", mult_busy, 0);
    check("smult_done_ready", id_ready, 1);
    tick();
    check("smult_add_valid", ex_valid, 1);
    check("smult_add_ctrl", ex_vec, exp_ctrl(0));

    // Stall in RUN holds a live instruction.
    id_opcode = 8'd3;
    tick();
    check("or_ctrl", ex_vec, exp_ctrl(3));
    ex_stall = 1'b1;
    id_opcode = 8'd9;
    #1 check("stall_ready", id_ready, 0);
    repeat (2) begin
      tick();
      check("stall_hold_valid", ex_valid, 1);
      check("stall_hold_ctrl", ex_vec, exp_ctrl(3));
    end
    ex_stall = 1'b0;
    tick();
    check("sll_ctrl", ex_vec, exp_ctrl(9));

    // Flush beats a simultaneous transfer; re-present afterwards.
    id_opcode = 8'd2;
    flush = 1'b1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_ctrl", ex_vec, 0);
    flush = 1'b0;
    tick();
    check("reload_valid", ex_valid, 1);
    check("reload_alu", ex_alu_op, 2);

    // Idle input gives a bubble.
    id_valid = 1'b0;
    tick();
    check("bubble_valid", ex_valid, 0);
    check("bubble_ctrl", ex_vec, 0);

    // Flush during MULT_WAIT does not disturb the counter.
    id_valid = 1'b1;
    id_opcode = 8'd13;
    tick();
    id_opcode = 8'd0;
    flush = 1'b1;
    tick();
    check("fmult_busy1", mult_busy, 1);
    check("fmult_valid1", ex_valid, 0);
    flush = 1'b0;
    tick();
    check("fmult_busy2", mult_busy, 1);
    tick();
    check("fmult_busy3", mult_busy, 0);
    check("fmult_ready3", id_ready, 1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    RESET = 1'b1;
    tick();
    check("trap_rst_seen", illegal_seen, 0);
    RESET = 1'b0;
    id_opcode = 8'd200;
    tick();
    check("trap_valid", ex_valid, 1);
    check("trap_ctrl", ex_vec, 0);
    check("trap_illegal", ex_illegal, 1);
    check("trap_seen", illegal_seen, 1);
    id_opcode = 8'd0;
    tick();
    check("trap_illegal_clr", ex_illegal, 0);
    check("trap_seen_sticky", illegal_seen, 1);
    RESET = 1'b1;
    tick();
    check("trap_seen_rst", illegal_seen, 0);
    RESET = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_ctrl_unit.md
Name: pipelined_ctrl_unit

Overview:
- Registered successor to the 8-bit combinational opcode decoder; forms the ID/EX control pipeline register of the RISC-style core.
- Decodes a valid opcode into ALU/regfile/branch controls and holds them for EX.
- Supports downstream stall, branch flush and a multi-cycle MULT interlock via a ready/valid handshake to fetch.
- Generalised: opcode and alu_op widths and multiplier latency are parameters.

Parameters:
- OPCODE_W, 8, opcode field width (>=4).
- ALU_OP_W, 4, alu_op width (>=4).
- MULT_LATENCY, 4, EX cycles MULT occupies (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- id_valid  in  1  opcode on id_opcode is valid.
- id_opcode  in  OPCODE_W  instruction opcode.
- id_ready  out  1  unit accepts id_opcode this cycle.
- ex_stall  in  1  EX cannot advance; hold all state.
- flush  in  1  branch/jump taken; kill instruction being accepted.
- ex_valid  out  1  ex_* fields hold a real instruction.
- ex_wrten, ex_cmplmnt_sel, ex_immd_sel, ex_jump, ex_branch, ex_bne  out  1 each  registered controls.
- ex_alu_op  out  ALU_OP_W  registered ALU select.
- mult_busy  out  1  MULT occupying EX beyond its first cycle.

Behaviour:
- One clock, synchronous active-high reset. No #delays. No X outputs: every don't-care decodes to 0.
- Reset values: all ex_* outputs 0, mult_busy 0, FSM RUN, counter 0. id_ready is 0 during RESET.
- Decode table (wrten, cmplmnt, immd, alu_op, jump, branch, bne):
  - 0 add: 1,1,0,1,0,0,0
  - 1 sub: 1,0,0,1,0,0,0
  - 2 and: 1,1,0,2,0,0,0
  - 3 or: 1,1,0,3,0,0,0
  - 4 mov: 1,1,0,0,0,0,0
  - 5 loadi: 1,0,1,0,0,0,0
  - 6 j: 0,0,0,0,1,0,0
  - 7 beq: 0,0,0,1,0,1,0
  - 8 ror: 1,0,1,4,0,0,0
  - 9 sll: 1,0,1,5,0,0,0
  - 10 srl: 1,0,1,6,0,0,0
  - 11 sra: 1,0,1,7,0,0,0
  - 12 bne: 0,0,0,1,0,0,1
  - 13 mult: 1,1,0,8,0,0,0
  - Any other value: illegal; all controls 0.
- id_ready = !RESET && !ex_stall && state==RUN.
- Handshake: a transfer happens when id_valid && id_ready. Latency is 1 cycle: decoded fields appear on ex_* the next cycle with ex_valid=1.
- Per-edge priority: RESET > ex_stall (hold everything, including FSM counter) > flush (ex_valid<=0, all controls<=0) > transfer (load decoded) > bubble (ex_valid<=0, controls<=0).
- Flush wins over a simultaneous transfer: the instruction is dropped and fetch must re-present it.
- Illegal opcode transfer: ex_valid<=1, all controls 0 (behaves as NOP).
- FSM, states RUN and MULT_WAIT:
  - RUN -> MULT_WAIT on a transfer of opcode 13 when MULT_LATENCY>1. Counter loads MULT_LATENCY-1.
  - In MULT_WAIT: mult_busy=1, ex_valid=0 from the second cycle, id_ready=0. Counter decrements on each non-stalled cycle.
  - MULT_WAIT -> RUN when the counter reaches 1 on a non-stalled edge. id_ready rises the following cycle.
  - MULT_LATENCY==1: MULT behaves as a single-cycle op; MULT_WAIT is never entered.
  - flush in MULT_WAIT: ex outputs are already a bubble; the counter is not affected.
- Counter width: $clog2(MULT_LATENCY)+1.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: adds output ex_illegal (1 bit), registered with the same priority rules. It is 1 with ex_valid when the transferred opcode is illegal. It also adds a sticky output illegal_seen, set on any illegal transfer and cleared only by RESET.
- Undefined: neither port exists; illegal opcodes act as a silent NOP.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams OP_ADD..OP_MULT;
  - ALU select constants ALU_FWD=0, ALU_ADD=1, ALU_AND=2, ALU_OR=3, ALU_ROR=4, ALU_SLL=5, ALU_SRL=6, ALU_SRA=7, ALU_MUL=8;
  - a packed struct ctrl_t of the seven control fields;
  - FSM state enum.
- One natural sub-module: ctrl_decode, purely combinational, opcode -> ctrl_t + illegal flag. pipelined_ctrl_unit instantiates it and owns the registers and FSM.

Test Plan:
- Reset: RESET=1 for 2 cycles with id_valid=1, opcode 0 -> all ex_* 0, id_ready 0. Deassert; next edge transfers add -> ex_valid=1, wrten=1, cmplmnt=1, alu_op=1.
- Sweep opcodes 0..13 then 14, 255 back-to-back -> each cycle's ex_* matches the table; 14 and 255 give ex_valid=1 with all controls 0.
- MULT_LATENCY=4: transfer opcode 13, then hold id_valid with opcode 0 -> ex_alu_op=8 for 1 cycle, mult_busy=1 and id_ready=0 for 3 cycles, add appears in the 5th cycle.
- ex_stall=1 for 3 cycles mid-MULT_WAIT -> counter frozen, ex_* constant, total MULT occupancy 4+3 cycles.
- flush and transfer of opcode 2 on the same edge -> ex_valid=0, controls 0; re-present opcode 2 next cycle -> ex_alu_op=2.
- With CTRL_ILLEGAL_TRAP_EN: transfer opcode 200 -> ex_illegal=1 for one cycle, illegal_seen stays 1 until RESET.
